ram_port_arbiter: RTL and testbench



---
 rtl/ram_port_arbiter_if.sv | 53 +++++
 rtl/ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Bundles the requester handshakes and the RAM primitive signals that
//   the arbiter sits between.
//   master : requester/RAM side (drives req/payload and ram_dout).
//   slave  : arbiter side (drives gnt, rdata, rvalid and ram_addr/din/we).
//   Signals:
//     cpu_req/cpu_we/cpu_addr/cpu_wdata  core request and payload
//     cpu_gnt/cpu_rdata/cpu_rvalid       core grant and read return
//     vga_req/vga_addr                   VGA read request (read-only port)
//     vga_gnt/vga_rdata/vga_rvalid       VGA grant and read return
//     ram_addr/ram_din/ram_we            registered RAM drive
//     ram_dout                           RAM read data
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output vga_req, vga_addr,
    input  vga_gnt, vga_rdata, vga_rvalid,
    input  ram_addr, ram_din, ram_we,
    output ram_dout
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  vga_req, vga_addr,
    output vga_gnt, vga_rdata, vga_rvalid,
    output ram_addr, ram_din, ram_we,
    input  ram_dout
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single-port display/program RAM between the CPU core and the
//   VGA pixel-fetch engine. One access is accepted per cycle (req/gnt, grant
//   is combinational). The winner's address/data/we are registered onto the
//   RAM, and a per-read owner tag follows the access so ram_dout is routed
//   back to whoever issued the read.
//   VGA has priority on contention. With RAM_ARB_STARVE_GUARD_EN defined, a
//   core that has been denied MAX_WAIT consecutive cycles is force-granted.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    ram_port_arbiter_if.slave (requesters + RAM primitive)
//   Parameters: ADDR_W, DATA_W, RD_LAT (1..3), MAX_WAIT (guard only).
module ram_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   bus
);

  if (RD_LAT < 1 || RD_LAT > 3 || MAX_WAIT < 1) begin : g_cfg_check
    $error("ram_port_arbiter: RD_LAT must be 1..3 and MAX_WAIT >= 1");
  end

  logic              cpu_gnt_c;
  logic              vga_gnt_c;
  logic              force_cpu;

  logic [ADDR_W-1:0] ram_addr_p0;
  logic [DATA_W-1:0] ram_din_p0;
  logic              ram_we_p0;

  // Owner tags: bit k is the read accepted k+1 edges ago.
  logic [RD_LAT:0]   tag_cpu_p;
  logic [RD_LAT:0]   tag_vga_p;

  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] vga_rdata_q;

`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  assign force_cpu = (wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (bus.cpu_req && !cpu_gnt_c) begin
      if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign force_cpu = 1'b0;
`endif

  // Grants are held low during reset so nothing is accepted while the
  // registers are being cleared.
  assign vga_gnt_c = rst_n & bus.vga_req & ~(bus.cpu_req & force_cpu);
  assign cpu_gnt_c = rst_n & bus.cpu_req & (~bus.vga_req | force_cpu);

  assign bus.cpu_gnt = cpu_gnt_c;
  assign bus.vga_gnt = vga_gnt_c;

  // Stage p0: winner registered onto the RAM port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_p0 <= '0;
      ram_din_p0  <= '0;
      ram_we_p0   <= 1'b0;
    end else begin
      ram_we_p0 <= 1'b0;
      if (cpu_gnt_c) begin
        ram_addr_p0 <= bus.cpu_addr;
        ram_din_p0  <= bus.cpu_wdata;
        ram_we_p0   <= bus.cpu_we;
      end else if (vga_gnt_c) begin
        ram_addr_p0 <= bus.vga_addr;
      end
    end
  end

  assign bus.ram_addr = ram_addr_p0;
  assign bus.ram_din  = ram_din_p0;
  assign bus.ram_we   = ram_we_p0;

  // Stages p0..pRD_LAT: read-owner tags, in step with the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cpu_p <= '0;
      tag_vga_p <= '0;
    end else begin
      tag_cpu_p <= {tag_cpu_p[RD_LAT-1:0], cpu_gnt_c & ~bus.cpu_we};
      tag_vga_p <= {tag_vga_p[RD_LAT-1:0], vga_gnt_c};
    end
  end

  // Return stage: ram_dout is valid in the cycle the tag reaches the end, so
  // rdata shows it directly during the pulse and a hold register keeps it
  // afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      if (tag_cpu_p[RD_LAT]) begin
        cpu_rdata_q <= bus.ram_dout;
      end
      if (tag_vga_p[RD_LAT]) begin
        vga_rdata_q <= bus.ram_dout;
      end
    end
  end

  assign bus.cpu_rvalid = tag_cpu_p[RD_LAT];
  assign bus.vga_rvalid = tag_vga_p[RD_LAT];
  assign bus.cpu_rdata  = tag_cpu_p[RD_LAT] ? bus.ram_dout : cpu_rdata_q;
  assign bus.vga_rdata  = tag_vga_p[RD_LAT] ? bus.ram_dout : vga_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Bench for ram_port_arbiter: drives both requesters, models the RAM
//   (write-first, RD_LAT cycles), and checks the DUT every cycle against a
//   transaction-level model (winner choice, queue of expected returns,
//   shadow memory), plus literal expectations for the directed scenarios.
//   Honours RAM_ARB_STARVE_GUARD_EN in the same way as the design.
module tb_ram_port_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 4;
`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_fail;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [15:0] init_val(input logic [14:0] a);
    return {1'b0, a} ^ 16'h1234;
  endfunction

  // RAM primitive: write-first, read data RD_LAT cycles after the address.
  logic [15:0] mem [0:32767];
  logic [15:0] dpipe [RD_LAT];

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = init_val(15'(i));
    for (int i = 0; i < RD_LAT; i++) dpipe[i] = '0;
  end

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    dpipe[0] <= bus.ram_we ? bus.ram_din : mem[bus.ram_addr];
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end

  assign bus.ram_dout = dpipe[RD_LAT-1];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model.
  typedef struct { int due; bit is_cpu; logic [15:0] data; } ret_t;
  ret_t        pend[$];
  logic [15:0] shadow [int];
  int          m_wait;
  logic [14:0] m_addr;
  logic [15:0] m_din;
  logic        m_we;
  logic [15:0] m_cpu_rdata;
  logic [15:0] m_vga_rdata;

  function automatic logic [15:0] model_read(input logic [14:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_val(a);
  endfunction

  initial begin
    m_wait = 0; m_addr = '0; m_din = '0; m_we = 1'b0;
    m_cpu_rdata = '0; m_vga_rdata = '0;
  end

  always @(negedge clk) begin
    bit   e_cv, e_vv, frc, win_cpu, win_vga;
    ret_t r;
    if (!rst_n) begin
      check("rst_cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
      check("rst_vga_gnt",    32'(bus.vga_gnt),    32'd0);
      check("rst_ram_we",     32'(bus.ram_we),     32'd0);
      check("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
      check("rst_ram_din",    32'(bus.ram_din),    32'd0);
      check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      check("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
      check("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
      check("rst_vga_rdata",  32'(bus.vga_rdata),  32'd0);
      pend.delete();
      m_wait = 0; m_addr = '0; m_din = '0; m_we = 1'b0;
      m_cpu_rdata = '0; m_vga_rdata = '0;
    end else begin
      e_cv = 1'b0; e_vv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.is_cpu) begin e_cv = 1'b1; m_cpu_rdata = r.data; end
        else          begin e_vv = 1'b1; m_vga_rdata = r.data; end
      end
      check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e_cv));
      check("vga_rvalid", 32'(bus.vga_rvalid), 32'(e_vv));
      check("cpu_rdata",  32'(bus.cpu_rdata),  32'(m_cpu_rdata));
      check("vga_rdata",  32'(bus.vga_rdata),  32'(m_vga_rdata));
      check("ram_addr",   32'(bus.ram_addr),   32'(m_addr));
      check("ram_din",    32'(bus.ram_din),    32'(m_din));
      check("ram_we",     32'(bus.ram_we),     32'(m_we));

      frc     = GUARD && (m_wait == MAX_WAIT);
      win_vga = bus.vga_req && !(bus.cpu_req && frc);
      win_cpu = bus.cpu_req && !win_vga;
      check("cpu_gnt", 32'(bus.cpu_gnt), 32'(win_cpu));
      check("vga_gnt", 32'(bus.vga_gnt), 32'(win_vga));

      m_we = 1'b0;
      if (win_cpu) begin
        m_addr = bus.cpu_addr;
        m_din  = bus.cpu_wdata;
        m_we   = bus.cpu_we;
        if (bus.cpu_we) shadow[int'(bus.cpu_addr)] = bus.cpu_wdata;
        else pend.push_back('{cyc + 1 + RD_LAT, 1'b1, model_read(bus.cpu_addr)});
      end else if (win_vga) begin
        m_addr = bus.vga_addr;
        pend.push_back('{cyc + 1 + RD_LAT, 1'b0, model_read(bus.vga_addr)});
      end
      if (bus.cpu_req && !win_cpu) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else                         m_wait = 0;
    end
  end

  // Return-pulse log used by the directed scenarios.
  typedef struct { int cyc; bit is_vga; logic [15:0] data; } pulse_t;
  pulse_t plog[$];

  always @(negedge clk) begin
    if (rst_n && bus.cpu_rvalid) plog.push_back('{cyc, 1'b0, bus.cpu_rdata});
    if (rst_n && bus.vga_rvalid) plog.push_back('{cyc, 1'b1, bus.vga_rdata});
  end

  task automatic drive(input bit cr, input bit cw, input logic [14:0] ca,
                       input logic [15:0] cd, input bit vr, input logic [14:0] va);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.vga_req   = vr;
    bus.vga_addr  = va;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cpu_cnt, vga_cnt, t0;
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 15'h0010, 16'h0000, 1'b1, 15'h0020);
    repeat (3) tick();
    check("lit_rst_cpu_gnt",  32'(bus.cpu_gnt),  32'd0);
    check("lit_rst_vga_gnt",  32'(bus.vga_gnt),  32'd0);
    check("lit_rst_ram_we",   32'(bus.ram_we),   32'd0);
    check("lit_rst_ram_addr", 32'(bus.ram_addr), 32'd0);

    // Contention straight out of reset.
    rst_n = 1'b1;
    #1;
    check("lit_first_vga_gnt", 32'(bus.vga_gnt), 32'd1);
    check("lit_first_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    cpu_cnt = 0;
    vga_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cpu_gnt) cpu_cnt++;
      if (bus.vga_gnt) vga_cnt++;
      tick();
    end
    check("lit_contend_cpu_grants", 32'(cpu_cnt), GUARD ? 32'd2 : 32'd0);
    check("lit_contend_vga_grants", 32'(vga_cnt), GUARD ? 32'd8 : 32'd10);
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 15'h0);
    repeat (RD_LAT + 3) tick();

    // Core write then read of the same address.
    plog.delete();
    t0 = cyc;
    drive(1'b1, 1'b1, 15'h4B10, 16'hBEEF, 1'b0, 15'h0);
    tick();
    drive(1'b1, 1'b0, 15'h4B10, 16'h0000, 1'b0, 15'h0);
    tick();
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 15'h0);
    repeat (RD_LAT + 4) tick();
    check("lit_wr_rd_pulses", 32'(plog.size()), 32'd1);
    if (plog.size() == 1) begin
      check("lit_wr_rd_owner", 32'(plog[0].is_vga), 32'd0);
      check("lit_wr_rd_data",  32'(plog[0].data),   32'h0000BEEF);
      check("lit_wr_rd_cycle", 32'(plog[0].cyc),    32'(t0 + 2 + RD_LAT));
    end
    check("lit_cpu_rdata_hold", 32'(bus.cpu_rdata), 32'h0000BEEF);

    // Alternating requesters, back to back.
    plog.delete();
    t0 = cyc;
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 15'h0000);
    tick();
    drive(1'b1, 1'b0, 15'h4B11, 16'h0, 1'b0, 15'h0);
    tick();
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 15'h0001);
    tick();
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 15'h0);
    repeat (RD_LAT + 3) tick();
    check("lit_alt_pulses", 32'(plog.size()), 32'd3);
    if (plog.size() == 3) begin
      check("lit_alt0_owner", 32'(plog[0].is_vga), 32'd1);
      check("lit_alt0_data",  32'(plog[0].data),   32'h00001234);
      check("lit_alt0_cycle", 32'(plog[0].cyc),    32'(t0 + 1 + RD_LAT));
      check("lit_alt1_owner", 32'(plog[1].is_vga), 32'd0);
      check("lit_alt1_data",  32'(plog[1].data),   32'h00005925);
      check("lit_alt1_cycle", 32'(plog[1].cyc),    32'(t0 + 2 + RD_LAT));
      check("lit_alt2_owner", 32'(plog[2].is_vga), 32'd1);
      check("lit_alt2_data",  32'(plog[2].data),   32'h00001235);
      check("lit_alt2_cycle", 32'(plog[2].cyc),    32'(t0 + 3 + RD_LAT));
    end

    // Top address, core write followed by VGA read of the same word.
    plog.delete();
    drive(1'b1, 1'b1, 15'h7FFF, 16'hCAFE, 1'b0, 15'h0);
    tick();
    check("lit_top_ram_addr", 32'(bus.ram_addr), 32'h00007FFF);
    check("lit_top_ram_din",  32'(bus.ram_din),  32'h0000CAFE);
    check("lit_top_ram_we",   32'(bus.ram_we),   32'd1);
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 15'h7FFF);
    tick();
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 15'h0);
    repeat (RD_LAT + 3) tick();
    check("lit_top_pulses", 32'(plog.size()), 32'd1);
    if (plog.size() == 1) begin
      check("lit_top_owner", 32'(plog[0].is_vga), 32'd1);
      check("lit_top_data",  32'(plog[0].data),   32'h0000CAFE);
    end

    // Reset one cycle after a VGA read is accepted drops the return.
    plog.delete();
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b1, 15'h0005);
    tick();
    drive(1'b0, 1'b0, 15'h0, 16'h0, 1'b0, 15'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (RD_LAT + 4) tick();
    check("lit_rst_drop_pulses", 32'(plog.size()), 32'd0);
    check("lit_rst_vga_rdata",   32'(bus.vga_rdata), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
